// File: rtl/bp_me_cache_mem_arbiter.sv
// Round-robin arbiter that merges cache-slice memory commands onto one port
// and routes in-order responses back through a tag FIFO of granted slices.
module bp_me_cache_mem_arbiter #(
  parameter int num_req_p   = 4,
  parameter int msg_width_p = 600,
  parameter int tag_els_p   = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]             mem_cmd_v_i,
  output logic [num_req_p-1:0]             mem_cmd_yumi_o,
  output logic [msg_width_p-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]             mem_resp_v_o,
  input  logic [num_req_p-1:0]             mem_resp_ready_i,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic [$clog2(tag_els_p+1)-1:0]   outstanding_o,
  output logic                             error_o
);

  localparam int idx_w = $clog2(num_req_p);
  localparam int ptr_w = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
  localparam int cnt_w = $clog2(tag_els_p+1);

  logic [msg_width_p-1:0] slot [num_req_p];

  for (genvar g = 0; g < num_req_p; g++) begin : g_slot
    assign slot[g] = mem_cmd_i[g*msg_width_p +: msg_width_p];
  end

  logic [msg_width_p-1:0] cmd_q, cmd_d;
  logic                   cmd_v_q, cmd_v_d;
  logic [idx_w-1:0]       rr_q, rr_d;
  logic [ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [idx_w-1:0]       tag_q [tag_els_p];

  logic             xfer, full, empty, grant_en, found, grant;
  logic             resp_go, pop;
  logic [idx_w:0]   sum;
  logic [idx_w-1:0] cand, gnt_idx, head;

  always_comb begin
    xfer     = cmd_v_q & mem_cmd_ready_i;
    full     = (cnt_q == cnt_w'(tag_els_p));
    empty    = (cnt_q == '0);
    // Reset gates the combinational accept so nothing leaks while held.
    grant_en = reset_n_i & (~cmd_v_q | xfer) & ~full;

    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < num_req_p; k++) begin
      sum = {1'b0, rr_q} + (idx_w+1)'(k);
      if (sum >= (idx_w+1)'(num_req_p))
        sum = sum - (idx_w+1)'(num_req_p);
      cand = sum[idx_w-1:0];
      if (!found && mem_cmd_v_i[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    grant = grant_en & found;

    mem_cmd_yumi_o = '0;
    if (grant)
      mem_cmd_yumi_o[gnt_idx] = 1'b1;

    head    = tag_q[rd_ptr_q];
    resp_go = mem_resp_v_i & ~empty;

    mem_resp_v_o = '0;
    if (resp_go)
      mem_resp_v_o[head] = 1'b1;
    pop = resp_go & mem_resp_ready_i[head];

    cmd_d   = cmd_q;
    cmd_v_d = cmd_v_q;
    rr_d    = rr_q;
    if (grant) begin
      cmd_d   = slot[gnt_idx];
      cmd_v_d = 1'b1;
      rr_d    = (gnt_idx == idx_w'(num_req_p-1)) ? '0 : gnt_idx + 1'b1;
    end else if (xfer) begin
      cmd_v_d = 1'b0;
    end

    wr_ptr_d = wr_ptr_q;
    if (grant)
      wr_ptr_d = (wr_ptr_q == ptr_w'(tag_els_p-1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = rd_ptr_q;
    if (pop)
      rd_ptr_d = (rd_ptr_q == ptr_w'(tag_els_p-1)) ? '0 : rd_ptr_q + 1'b1;

    cnt_d = cnt_q;
    unique case ({grant, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q | (mem_resp_v_i & empty);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_q    <= '0;
      cmd_v_q  <= 1'b0;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < tag_els_p; i++)
        tag_q[i] <= '0;
    end else begin
      cmd_q    <= cmd_d;
      cmd_v_q  <= cmd_v_d;
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (grant)
        tag_q[wr_ptr_q] <= gnt_idx;
    end
  end

  assign mem_cmd_o       = cmd_q;
  assign mem_cmd_v_o     = cmd_v_q;
  assign mem_resp_o      = mem_resp_i;
  assign mem_resp_yumi_o = pop;
  assign outstanding_o   = cnt_q;
  assign error_o         = err_q;

endmodule

// File: tb/tb_bp_me_cache_mem_arbiter.sv
// Directed bench for bp_me_cache_mem_arbiter: arbitration order, stalls,
// tag FIFO full/drain, head-of-line blocking, error flag and async reset.
module tb_bp_me_cache_mem_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int T = 4;

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [N*W-1:0] mem_cmd_i;
  logic [N-1:0]   mem_cmd_v_i;
  logic [N-1:0]   mem_cmd_yumi_o;
  logic [W-1:0]   mem_resp_o;
  logic [N-1:0]   mem_resp_v_o;
  logic [N-1:0]   mem_resp_ready_i;
  logic [W-1:0]   mem_cmd_o;
  logic           mem_cmd_v_o;
  logic           mem_cmd_ready_i;
  logic [W-1:0]   mem_resp_i;
  logic           mem_resp_v_i;
  logic           mem_resp_yumi_o;
  logic [2:0]     outstanding_o;
  logic           error_o;

  int total = 0;
  int bad   = 0;

  bp_me_cache_mem_arbiter #(
    .num_req_p(N), .msg_width_p(W), .tag_els_p(T)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i),
    .mem_cmd_yumi_o(mem_cmd_yumi_o),
    .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o),
    .mem_resp_ready_i(mem_resp_ready_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i),
    .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] pay(int i);
    return W'(16'hC000 + i);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    mem_cmd_i        = {pay(3), pay(2), pay(1), pay(0)};
    mem_cmd_v_i      = '0;
    mem_resp_ready_i = '1;
    mem_cmd_ready_i  = 1'b1;
    mem_resp_i       = 16'h5A5A;
    mem_resp_v_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n_i    = 1'b0;
    mem_cmd_v_i  = 4'hF;
    mem_resp_v_i = 1'b1;
    #1;
    total++;
    if (mem_cmd_yumi_o !== 4'h0) begin
      bad++;
      $display("FAIL rst_yumi got=%h exp=0", mem_cmd_yumi_o);
    end
    tick();
    total++;
    if ({mem_cmd_v_o, mem_resp_v_o, mem_resp_yumi_o} !== 6'b0) begin
      bad++;
      $display("FAIL rst_v got=%b %h %b exp=0 0 0",
               mem_cmd_v_o, mem_resp_v_o, mem_resp_yumi_o);
    end
    total++;
    if (outstanding_o !== 3'd0 || error_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_state got=%0d %b exp=0 0",
               outstanding_o, error_o);
    end
    idle_inputs();
    reset_n_i = 1'b1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      mem_cmd_v_i  = 4'hF;
      mem_resp_v_i = (k >= 1);
      #1;
      total++;
      if (mem_cmd_yumi_o !== 4'(1 << (k % 4))) begin
        bad++;
        $display("FAIL rr_yumi k=%0d got=%h exp=%h",
                 k, mem_cmd_yumi_o, 4'(1 << (k % 4)));
      end
      if (k >= 1) begin
        total++;
        if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== pay((k-1) % 4)) begin
          bad++;
          $display("FAIL rr_cmd k=%0d got=%b %h exp=1 %h",
                   k, mem_cmd_v_o, mem_cmd_o, pay((k-1) % 4));
        end
        total++;
        if (mem_resp_v_o !== 4'(1 << ((k-1) % 4)) ||
            mem_resp_yumi_o !== 1'b1) begin
          bad++;
          $display("FAIL rr_resp k=%0d got=%h %b exp=%h 1",
                   k, mem_resp_v_o, mem_resp_yumi_o,
                   4'(1 << ((k-1) % 4)));
        end
      end
      tick();
    end
    mem_cmd_v_i  = '0;
    mem_resp_v_i = 1'b1;
    #1;
    total++;
    if (mem_cmd_o !== pay(1) || mem_resp_v_o !== 4'b0010 ||
        mem_cmd_yumi_o !== 4'h0) begin
      bad++;
      $display("FAIL rr_tail got=%h %h %h exp=%h 2 0",
               mem_cmd_o, mem_resp_v_o, mem_cmd_yumi_o, pay(1));
    end
    tick();
    mem_resp_v_i = 1'b0;
    #1;
    total++;
    if (mem_cmd_v_o !== 1'b0 || outstanding_o !== 3'd0 ||
        error_o !== 1'b0) begin
      bad++;
      $display("FAIL rr_end got=%b %0d %b exp=0 0 0",
               mem_cmd_v_o, outstanding_o, error_o);
    end
  endtask

  task automatic test_stall();
    do_reset();
    mem_cmd_ready_i = 1'b0;
    mem_cmd_v_i     = 4'b0100;
    #1;
    total++;
    if (mem_cmd_yumi_o !== 4'b0100) begin
      bad++;
      $display("FAIL st_grant got=%h exp=4", mem_cmd_yumi_o);
    end
    tick();
    mem_cmd_i[2*W +: W] = 16'hD002;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== pay(2) ||
          mem_cmd_yumi_o !== 4'h0) begin
        bad++;
        $display("FAIL st_hold c=%0d got=%b %h %h exp=1 %h 0",
                 c, mem_cmd_v_o, mem_cmd_o, mem_cmd_yumi_o, pay(2));
      end
      tick();
    end
    mem_cmd_ready_i = 1'b1;
    #1;
    total++;
    if (mem_cmd_yumi_o !== 4'b0100 || mem_cmd_o !== pay(2)) begin
      bad++;
      $display("FAIL st_xfer got=%h %h exp=4 %h",
               mem_cmd_yumi_o, mem_cmd_o, pay(2));
    end
    tick();
    mem_cmd_v_i = '0;
    #1;
    total++;
    if (mem_cmd_o !== 16'hD002 || outstanding_o !== 3'd2) begin
      bad++;
      $display("FAIL st_next got=%h %0d exp=d002 2",
               mem_cmd_o, outstanding_o);
    end
  endtask

  task automatic test_full_drain();
    logic [N-1:0] order [4];
    order[0] = 4'b1000;
    order[1] = 4'b0010;
    order[2] = 4'b0001;
    order[3] = 4'b0100;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      mem_cmd_v_i = order[k];
      #1;
      total++;
      if (mem_cmd_yumi_o !== order[k]) begin
        bad++;
        $display("FAIL fl_grant k=%0d got=%h exp=%h",
                 k, mem_cmd_yumi_o, order[k]);
      end
      tick();
    end
    mem_cmd_v_i = 4'hF;
    #1;
    total++;
    if (outstanding_o !== 3'd4 || mem_cmd_yumi_o !== 4'h0) begin
      bad++;
      $display("FAIL fl_full got=%0d %h exp=4 0",
               outstanding_o, mem_cmd_yumi_o);
    end
    tick();
    mem_cmd_v_i  = '0;
    mem_resp_v_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_resp_i = W'(16'hE000 + k);
      #1;
      total++;
      if (mem_resp_v_o !== order[k] || mem_resp_yumi_o !== 1'b1 ||
          mem_resp_o !== W'(16'hE000 + k)) begin
        bad++;
        $display("FAIL fl_resp k=%0d got=%h %b %h exp=%h 1 %h",
                 k, mem_resp_v_o, mem_resp_yumi_o, mem_resp_o,
                 order[k], W'(16'hE000 + k));
      end
      tick();
    end
    mem_resp_v_i = 1'b0;
    #1;
    total++;
    if (outstanding_o !== 3'd0 || error_o !== 1'b0) begin
      bad++;
      $display("FAIL fl_drained got=%0d %b exp=0 0",
               outstanding_o, error_o);
    end
  endtask

  task automatic test_head_of_line();
    do_reset();
    mem_cmd_v_i = 4'b0010;
    tick();
    mem_cmd_v_i      = '0;
    mem_resp_v_i     = 1'b1;
    mem_resp_i       = 16'hBEEF;
    mem_resp_ready_i = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (mem_resp_v_o !== 4'b0010 || mem_resp_yumi_o !== 1'b0 ||
          mem_resp_o !== 16'hBEEF) begin
        bad++;
        $display("FAIL hol_wait c=%0d got=%h %b %h exp=2 0 beef",
                 c, mem_resp_v_o, mem_resp_yumi_o, mem_resp_o);
      end
      tick();
    end
    mem_resp_ready_i = 4'hF;
    #1;
    total++;
    if (mem_resp_yumi_o !== 1'b1 || mem_resp_o !== 16'hBEEF) begin
      bad++;
      $display("FAIL hol_go got=%b %h exp=1 beef",
               mem_resp_yumi_o, mem_resp_o);
    end
    tick();
    mem_resp_v_i = 1'b0;
    #1;
    total++;
    if (outstanding_o !== 3'd0 || error_o !== 1'b0) begin
      bad++;
      $display("FAIL hol_end got=%0d %b exp=0 0",
               outstanding_o, error_o);
    end
  endtask

  task automatic test_error();
    mem_resp_v_i = 1'b1;
    #1;
    total++;
    if (mem_resp_yumi_o !== 1'b0 || mem_resp_v_o !== 4'h0) begin
      bad++;
      $display("FAIL err_yumi got=%b %h exp=0 0",
               mem_resp_yumi_o, mem_resp_v_o);
    end
    tick();
    mem_resp_v_i = 1'b0;
    #1;
    total++;
    if (error_o !== 1'b1) begin
      bad++;
      $display("FAIL err_set got=%b exp=1", error_o);
    end
    tick();
    tick();
    total++;
    if (error_o !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got=%b exp=1", error_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_cmd_v_i = 4'b0001;
    tick();
    mem_cmd_v_i = 4'b0010;
    tick();
    mem_cmd_v_i     = '0;
    mem_cmd_ready_i = 1'b0;
    #1;
    total++;
    if (outstanding_o !== 3'd2 || mem_cmd_v_o !== 1'b1) begin
      bad++;
      $display("FAIL rm_pre got=%0d %b exp=2 1",
               outstanding_o, mem_cmd_v_o);
    end
    mem_cmd_v_i  = 4'hF;
    mem_resp_v_i = 1'b1;
    reset_n_i    = 1'b0;
    #1;
    total++;
    if ({mem_cmd_v_o, mem_cmd_yumi_o, mem_resp_v_o,
         mem_resp_yumi_o, outstanding_o, error_o} !== 14'b0) begin
      bad++;
      $display("FAIL rm_async got=%b %h %h %b %0d %b exp=all 0",
               mem_cmd_v_o, mem_cmd_yumi_o, mem_resp_v_o,
               mem_resp_yumi_o, outstanding_o, error_o);
    end
    tick();
    mem_cmd_v_i     = '0;
    mem_resp_v_i    = 1'b0;
    mem_cmd_ready_i = 1'b1;
    reset_n_i       = 1'b1;
    tick();
    total++;
    if (mem_cmd_v_o !== 1'b0 || mem_resp_v_o !== 4'h0) begin
      bad++;
      $display("FAIL rm_quiet got=%b %h exp=0 0",
               mem_cmd_v_o, mem_resp_v_o);
    end
    mem_cmd_v_i = 4'hF;
    #1;
    total++;
    if (mem_cmd_yumi_o !== 4'b0001) begin
      bad++;
      $display("FAIL rm_first got=%h exp=1", mem_cmd_yumi_o);
    end
    tick();
    mem_cmd_v_i = '0;
  endtask

  initial begin
    idle_inputs();
    reset_n_i = 1'b1;
    #3;
    test_reset();
    test_round_robin();
    test_stall();
    test_full_drain();
    test_head_of_line();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
